// File: rtl/pmu_pgc_multi.sv
// -----------------------------------------------------------------------------
// pmu_pgc_multi
//   Low-power controller for a single CPU core. It sits between the CPU
//   low-power mode request (biu_pad_lpmd_b) and the core clock-gate, isolation,
//   power-switch and reset controls. It has NUM_WAKE maskable wake sources,
//   each with a sticky pending bit. The power-gating sequence has a
//   programmable per-step delay. A wake that arrives before the power switch
//   acknowledges power-off aborts the power-down sequence.
//
// Ports
//   pmu_clk, pad_cpu_rst_b    clock and asynchronous active-low reset
//   apb_pmu_*                 APB slave, zero wait state
//   pmu_apb_prdata            combinational read data
//   biu_pad_lpmd_b            low-power request: 11 run, 10 doze, 01 wait,
//                             00 stop
//   wake_src                  level wake requests; a rising edge is captured
//   corec_pmu_sleep_out       power-switch acknowledge (1 = core off)
//   gate_en0 / gate_en1       core clock enable / bus clock enable
//   pmu_corec_sleep_in        power-off request to the switch
//   pmu_corec_isolation       core output isolation
//   pg_reset_b                core reset, active low
//   pmu_wake_irq              |(pend & wake_en)
//
// Register map
//   0x0 CTRL  RW    [NUM_WAKE-1:0] wake_en, [31] pg_en
//   0x4 STEP  RW    [DLY_W-1:0] step_dly
//   0x8 PEND  RW1C  [NUM_WAKE-1:0]
//   0xC STAT  RO    {24'b0, pg_state, 1'b0, lp_state}
// -----------------------------------------------------------------------------
module pmu_pgc_multi #(
  parameter int NUM_WAKE = 4,
  parameter int DLY_W    = 8
) (
  input  logic                pmu_clk,
  input  logic                pad_cpu_rst_b,
  input  logic                apb_pmu_psel,
  input  logic                apb_pmu_penable,
  input  logic                apb_pmu_pwrite,
  input  logic [11:0]         apb_pmu_paddr,
  input  logic [31:0]         apb_pmu_pwdata,
  output logic [31:0]         pmu_apb_prdata,
  input  logic [1:0]          biu_pad_lpmd_b,
  input  logic [NUM_WAKE-1:0] wake_src,
  input  logic                corec_pmu_sleep_out,
  output logic                gate_en0,
  output logic                gate_en1,
  output logic                pmu_corec_sleep_in,
  output logic                pmu_corec_isolation,
  output logic                pg_reset_b,
  output logic                pmu_wake_irq
);

  localparam logic [11:0] ADDR_CTRL = 12'h000;
  localparam logic [11:0] ADDR_STEP = 12'h004;
  localparam logic [11:0] ADDR_PEND = 12'h008;
  localparam logic [11:0] ADDR_STAT = 12'h00C;

  localparam logic [DLY_W-1:0] DLY_ZERO = {DLY_W{1'b0}};
  localparam logic [DLY_W-1:0] DLY_ONE  = DLY_W'(32'd1);

  typedef enum logic [2:0] {
    LP_IDLE  = 3'd0,
    LP_DOZE  = 3'd1,
    LP_WAIT  = 3'd2,
    LP_STOP  = 3'd3,
    LP_AWAKE = 3'd4
  } lp_t;

  typedef enum logic [3:0] {
    PG_IDLE   = 4'd0,
    PG_RSTON  = 4'd1,
    PG_ISOON  = 4'd2,
    PG_OFFREQ = 4'd3,
    PG_OFF    = 4'd4,
    PG_ON     = 4'd5,
    PG_ISOOFF = 4'd6,
    PG_RSTOFF = 4'd7
  } pg_t;

  // Steps whose duration is set by the step-delay counter.
  function automatic logic is_timed(input pg_t st);
    logic res;
    case (st)
      PG_RSTON, PG_ISOON, PG_ISOOFF, PG_RSTOFF: res = 1'b1;
      default:                                  res = 1'b0;
    endcase
    return res;
  endfunction

  lp_t                 lp_state;
  lp_t                 lp_next;
  pg_t                 pg_state;
  pg_t                 pg_next;
  logic [NUM_WAKE-1:0] wake_en;
  logic                pg_en;
  logic [DLY_W-1:0]    step_dly;
  logic [NUM_WAKE-1:0] pend;
  logic [NUM_WAKE-1:0] wake_q;
  logic [DLY_W-1:0]    dly_cnt;
  logic [DLY_W-1:0]    dly_next;

  logic                wr_en;
  logic                lp_active;
  logic [NUM_WAKE-1:0] wake_rise;
  logic [NUM_WAKE-1:0] pend_set;
  logic [NUM_WAKE-1:0] pend_clr;
  logic [NUM_WAKE-1:0] pend_next;
  logic                wakeup;
  logic                dly_done;
  logic [31:0]         rdata;
  logic                unused_bits;

  assign wr_en     = apb_pmu_psel & apb_pmu_penable & apb_pmu_pwrite;
  assign lp_active = (biu_pad_lpmd_b != 2'b11);
  assign wake_rise = wake_src & ~wake_q;
  // Edges are only latched while the CPU is asking for a low-power mode.
  assign pend_set  = lp_active ? wake_rise : {NUM_WAKE{1'b0}};
  assign pend_clr  = (wr_en && (apb_pmu_paddr == ADDR_PEND)) ?
                     apb_pmu_pwdata[NUM_WAKE-1:0] : {NUM_WAKE{1'b0}};
  // A new edge wins over a same-cycle write-one-to-clear.
  assign pend_next = (pend & ~pend_clr) | pend_set;
  assign wakeup    = |(pend & wake_en);
  assign dly_done  = (dly_cnt == DLY_ZERO);

  // Write-data bits with no register behind them.
  assign unused_bits = ^apb_pmu_pwdata;

  // Configuration registers written from APB.
  always_ff @(posedge pmu_clk or negedge pad_cpu_rst_b) begin
    if (!pad_cpu_rst_b) begin
      wake_en  <= {NUM_WAKE{1'b0}};
      pg_en    <= 1'b0;
      step_dly <= DLY_ZERO;
    end else begin
      if (wr_en && (apb_pmu_paddr == ADDR_CTRL)) begin
        wake_en <= apb_pmu_pwdata[NUM_WAKE-1:0];
        pg_en   <= apb_pmu_pwdata[31];
      end
      if (wr_en && (apb_pmu_paddr == ADDR_STEP)) begin
        step_dly <= apb_pmu_pwdata[DLY_W-1:0];
      end
    end
  end

  // Wake edge detector and sticky pending bits.
  always_ff @(posedge pmu_clk or negedge pad_cpu_rst_b) begin
    if (!pad_cpu_rst_b) begin
      wake_q <= {NUM_WAKE{1'b0}};
      pend   <= {NUM_WAKE{1'b0}};
    end else begin
      wake_q <= wake_src;
      pend   <= pend_next;
    end
  end

  // State registers for both FSMs and the step-delay counter.
  always_ff @(posedge pmu_clk or negedge pad_cpu_rst_b) begin
    if (!pad_cpu_rst_b) begin
      lp_state <= LP_IDLE;
      pg_state <= PG_IDLE;
      dly_cnt  <= DLY_ZERO;
    end else begin
      lp_state <= lp_next;
      pg_state <= pg_next;
      dly_cnt  <= dly_next;
    end
  end

  // Low-power mode FSM next-state logic.
  always_comb begin
    lp_next = lp_state;
    case (lp_state)
      LP_IDLE: begin
        case (biu_pad_lpmd_b)
          2'b10:   lp_next = LP_DOZE;
          2'b01:   lp_next = LP_WAIT;
          // Stop without power gating enabled is treated as doze.
          2'b00:   lp_next = pg_en ? LP_STOP : LP_DOZE;
          default: lp_next = LP_IDLE;
        endcase
      end
      LP_DOZE, LP_WAIT: begin
        if (wakeup) begin
          lp_next = LP_AWAKE;
        end else begin
          lp_next = lp_state;
        end
      end
      LP_STOP: begin
        // Leave stop together with the final power-gating step.
        if ((pg_state == PG_RSTOFF) && dly_done) begin
          lp_next = LP_AWAKE;
        end else begin
          lp_next = LP_STOP;
        end
      end
      LP_AWAKE: begin
        if (biu_pad_lpmd_b == 2'b11) begin
          lp_next = LP_IDLE;
        end else begin
          lp_next = LP_AWAKE;
        end
      end
      default: lp_next = LP_IDLE;
    endcase
  end

  // Power-gating FSM next-state logic.
  always_comb begin
    pg_next = pg_state;
    case (pg_state)
      PG_IDLE: begin
        if (lp_state == LP_STOP) begin
          pg_next = PG_RSTON;
        end else begin
          pg_next = PG_IDLE;
        end
      end
      PG_RSTON: begin
        if (wakeup) begin
          pg_next = PG_ISOOFF;
        end else if (dly_done) begin
          pg_next = PG_ISOON;
        end else begin
          pg_next = PG_RSTON;
        end
      end
      PG_ISOON: begin
        if (wakeup) begin
          pg_next = PG_ISOOFF;
        end else if (dly_done) begin
          pg_next = PG_OFFREQ;
        end else begin
          pg_next = PG_ISOON;
        end
      end
      PG_OFFREQ: begin
        // Once the switch acknowledges, the wake has to go through OFF/ON.
        if (corec_pmu_sleep_out) begin
          pg_next = PG_OFF;
        end else if (wakeup) begin
          pg_next = PG_ISOOFF;
        end else begin
          pg_next = PG_OFFREQ;
        end
      end
      PG_OFF: begin
        if (wakeup) begin
          pg_next = PG_ON;
        end else begin
          pg_next = PG_OFF;
        end
      end
      PG_ON: begin
        if (!corec_pmu_sleep_out) begin
          pg_next = PG_ISOOFF;
        end else begin
          pg_next = PG_ON;
        end
      end
      PG_ISOOFF: begin
        if (dly_done) begin
          pg_next = PG_RSTOFF;
        end else begin
          pg_next = PG_ISOOFF;
        end
      end
      PG_RSTOFF: begin
        if (dly_done) begin
          pg_next = PG_IDLE;
        end else begin
          pg_next = PG_RSTOFF;
        end
      end
      default: pg_next = PG_IDLE;
    endcase
  end

  // Step-delay counter: loads step_dly on entry to a timed step, then counts
  // down to zero, so each timed step lasts step_dly+1 cycles.
  always_comb begin
    dly_next = dly_cnt;
    if ((pg_next != pg_state) && is_timed(pg_next)) begin
      dly_next = step_dly;
    end else if (!dly_done) begin
      dly_next = dly_cnt - DLY_ONE;
    end else begin
      dly_next = dly_cnt;
    end
  end

  // APB read mux; drives zero outside read accesses and for unmapped addresses.
  always_comb begin
    rdata = 32'd0;
    if (apb_pmu_psel && !apb_pmu_pwrite) begin
      case (apb_pmu_paddr)
        ADDR_CTRL: begin
          rdata[NUM_WAKE-1:0] = wake_en;
          rdata[31]           = pg_en;
        end
        ADDR_STEP: rdata[DLY_W-1:0]    = step_dly;
        ADDR_PEND: rdata[NUM_WAKE-1:0] = pend;
        ADDR_STAT: begin
          rdata[7:4] = pg_state;
          rdata[2:0] = lp_state;
        end
        default: rdata = 32'd0;
      endcase
    end else begin
      rdata = 32'd0;
    end
  end

  assign pmu_apb_prdata      = rdata;
  assign gate_en0            = (lp_state == LP_IDLE) || (lp_state == LP_AWAKE);
  assign gate_en1            = (lp_state == LP_IDLE) || (lp_state == LP_AWAKE) ||
                               (lp_state == LP_WAIT);
  assign pmu_corec_sleep_in  = (pg_state == PG_OFFREQ) || (pg_state == PG_OFF);
  assign pmu_corec_isolation = (pg_state == PG_ISOON) || (pg_state == PG_OFFREQ) ||
                               (pg_state == PG_OFF) || (pg_state == PG_ON) ||
                               (pg_state == PG_ISOOFF);
  // The reset pad is combined directly so the core stays in reset while the pad is low.
  assign pg_reset_b          = pad_cpu_rst_b & (pg_state == PG_IDLE);
  assign pmu_wake_irq        = wakeup;

endmodule

// File: tb/tb_pmu_pgc_multi.sv
// -----------------------------------------------------------------------------
// tb_pmu_pgc_multi
//   Directed bench for pmu_pgc_multi: doze wake, masked wake in wait, full
//   power-gating sequence, abort during ISOON, W1C/set race, and reset in OFF.
// -----------------------------------------------------------------------------
module tb_pmu_pgc_multi;

  localparam int NW = 4;

  logic          pmu_clk = 1'b0;
  logic          pad_cpu_rst_b = 1'b0;
  logic          psel = 1'b0;
  logic          penable = 1'b0;
  logic          pwrite = 1'b0;
  logic [11:0]   paddr = 12'h000;
  logic [31:0]   pwdata = 32'd0;
  logic [31:0]   prdata;
  logic [1:0]    lpmd_b = 2'b11;
  logic [NW-1:0] wake_src = 4'b0000;
  logic          sleep_out = 1'b0;
  logic          gate_en0, gate_en1, sleep_in, iso, pg_reset_b, irq;

  int checks = 0;
  int errors = 0;

  pmu_pgc_multi #(.NUM_WAKE(NW), .DLY_W(8)) dut (
    .pmu_clk             (pmu_clk),
    .pad_cpu_rst_b       (pad_cpu_rst_b),
    .apb_pmu_psel        (psel),
    .apb_pmu_penable     (penable),
    .apb_pmu_pwrite      (pwrite),
    .apb_pmu_paddr       (paddr),
    .apb_pmu_pwdata      (pwdata),
    .pmu_apb_prdata      (prdata),
    .biu_pad_lpmd_b      (lpmd_b),
    .wake_src            (wake_src),
    .corec_pmu_sleep_out (sleep_out),
    .gate_en0            (gate_en0),
    .gate_en1            (gate_en1),
    .pmu_corec_sleep_in  (sleep_in),
    .pmu_corec_isolation (iso),
    .pg_reset_b          (pg_reset_b),
    .pmu_wake_irq        (irq)
  );

  always #5 pmu_clk = ~pmu_clk;

  task automatic step();
    @(posedge pmu_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic apb_write(input logic [11:0] a, input logic [31:0] d);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = d;
    step();
    penable = 1'b1;
    step();
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic chk_reg(input string tag, input logic [11:0] a, input logic [31:0] exp);
    logic [31:0] d;
    psel = 1'b1; penable = 1'b1; pwrite = 1'b0; paddr = a;
    #1;
    d = prdata;
    psel = 1'b0; penable = 1'b0;
    #1;
    chk(tag, d, exp);
  endtask

  initial begin
    // ---------------- reset ----------------
    step(); step();
    chk("rst_pg_reset_b", 32'(pg_reset_b), 32'd0);
    chk("rst_gate_en0", 32'(gate_en0), 32'd1);
    chk("rst_gate_en1", 32'(gate_en1), 32'd1);
    chk("rst_sleep_in", 32'(sleep_in), 32'd0);
    chk("rst_iso", 32'(iso), 32'd0);
    chk("rst_irq", 32'(irq), 32'd0);
    chk_reg("rst_stat", 12'h00C, 32'h0000_0000);
    pad_cpu_rst_b = 1'b1;
    step();
    chk("rel_pg_reset_b", 32'(pg_reset_b), 32'd1);
    chk_reg("unmapped_rd", 12'h010, 32'h0000_0000);

    // ---------------- T1 doze ----------------
    apb_write(12'h000, 32'h0000_0001);
    chk_reg("t1_ctrl", 12'h000, 32'h0000_0001);
    lpmd_b = 2'b10;
    step();
    chk("t1_doze_ge0", 32'(gate_en0), 32'd0);
    chk("t1_doze_ge1", 32'(gate_en1), 32'd0);
    chk_reg("t1_stat_doze", 12'h00C, 32'h0000_0001);
    wake_src = 4'b0001;
    step();
    wake_src = 4'b0000;
    chk("t1_irq", 32'(irq), 32'd1);
    chk("t1_ge0_still0", 32'(gate_en0), 32'd0);
    step();
    chk("t1_ge0_awake", 32'(gate_en0), 32'd1);
    chk_reg("t1_stat_awake", 12'h00C, 32'h0000_0004);
    chk_reg("t1_pend", 12'h008, 32'h0000_0001);
    lpmd_b = 2'b11;
    step();
    chk_reg("t1_stat_idle", 12'h00C, 32'h0000_0000);
    apb_write(12'h008, 32'h0000_0001);
    chk_reg("t1_pend_clr", 12'h008, 32'h0000_0000);
    chk("t1_irq_clr", 32'(irq), 32'd0);

    // ---------------- T2 masked wake in wait ----------------
    apb_write(12'h000, 32'h0000_0002);
    lpmd_b = 2'b01;
    step();
    chk("t2_wait_ge0", 32'(gate_en0), 32'd0);
    chk("t2_wait_ge1", 32'(gate_en1), 32'd1);
    wake_src = 4'b0001;
    step();
    wake_src = 4'b0000;
    step();
    chk_reg("t2_stat_wait", 12'h00C, 32'h0000_0002);
    chk("t2_ge1", 32'(gate_en1), 32'd1);
    chk("t2_irq_masked", 32'(irq), 32'd0);
    chk_reg("t2_pend", 12'h008, 32'h0000_0001);
    apb_write(12'h008, 32'h0000_0001);
    chk_reg("t2_pend_clr", 12'h008, 32'h0000_0000);
    wake_src = 4'b0010;
    step();
    wake_src = 4'b0000;
    step();
    chk_reg("t2_stat_awake", 12'h00C, 32'h0000_0004);
    lpmd_b = 2'b11;
    step();
    apb_write(12'h008, 32'h0000_0002);
    chk_reg("t2_idle", 12'h00C, 32'h0000_0000);

    // ---------------- T3 full power-gating sequence ----------------
    apb_write(12'h004, 32'h0000_0003);
    apb_write(12'h000, 32'h8000_0001);
    chk_reg("t3_step", 12'h004, 32'h0000_0003);
    chk_reg("t3_ctrl", 12'h000, 32'h8000_0001);
    lpmd_b = 2'b00;
    step();
    chk_reg("t3_stop", 12'h00C, 32'h0000_0003);
    chk("t3_stop_ge0", 32'(gate_en0), 32'd0);
    step();
    chk_reg("t3_rston0", 12'h00C, 32'h0000_0013);
    chk("t3_rston_rb", 32'(pg_reset_b), 32'd0);
    chk("t3_rston_iso", 32'(iso), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk_reg("t3_rston", 12'h00C, 32'h0000_0013);
    end
    step();
    chk_reg("t3_isoon0", 12'h00C, 32'h0000_0023);
    chk("t3_isoon_iso", 32'(iso), 32'd1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk_reg("t3_isoon", 12'h00C, 32'h0000_0023);
    end
    step();
    chk_reg("t3_offreq", 12'h00C, 32'h0000_0033);
    chk("t3_offreq_sin", 32'(sleep_in), 32'd1);
    step(); step();
    chk_reg("t3_offreq_hold", 12'h00C, 32'h0000_0033);
    sleep_out = 1'b1;
    step();
    chk_reg("t3_off", 12'h00C, 32'h0000_0043);
    chk("t3_off_sin", 32'(sleep_in), 32'd1);
    step();
    wake_src = 4'b0001;
    step();
    wake_src = 4'b0000;
    chk("t3_irq", 32'(irq), 32'd1);
    chk_reg("t3_off_hold", 12'h00C, 32'h0000_0043);
    step();
    chk_reg("t3_on", 12'h00C, 32'h0000_0053);
    chk("t3_on_sin", 32'(sleep_in), 32'd0);
    chk("t3_on_iso", 32'(iso), 32'd1);
    step();
    chk_reg("t3_on_hold", 12'h00C, 32'h0000_0053);
    sleep_out = 1'b0;
    step();
    chk_reg("t3_isooff0", 12'h00C, 32'h0000_0063);
    for (int i = 0; i < 3; i++) begin
      step();
      chk_reg("t3_isooff", 12'h00C, 32'h0000_0063);
      chk("t3_isooff_iso", 32'(iso), 32'd1);
    end
    step();
    chk_reg("t3_rstoff0", 12'h00C, 32'h0000_0073);
    chk("t3_rstoff_iso", 32'(iso), 32'd0);
    chk("t3_rstoff_rb", 32'(pg_reset_b), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk_reg("t3_rstoff", 12'h00C, 32'h0000_0073);
    end
    step();
    chk_reg("t3_done", 12'h00C, 32'h0000_0004);
    chk("t3_done_rb", 32'(pg_reset_b), 32'd1);
    chk("t3_done_ge0", 32'(gate_en0), 32'd1);
    lpmd_b = 2'b11;
    step();
    apb_write(12'h008, 32'h0000_0001);
    chk_reg("t3_idle", 12'h00C, 32'h0000_0000);

    // ---------------- T4 abort during ISOON ----------------
    lpmd_b = 2'b00;
    step();
    step();
    chk_reg("t4_rston0", 12'h00C, 32'h0000_0013);
    step(); step(); step(); step();
    chk_reg("t4_isoon0", 12'h00C, 32'h0000_0023);
    wake_src = 4'b0001;
    step();
    wake_src = 4'b0000;
    chk_reg("t4_isoon1", 12'h00C, 32'h0000_0023);
    step();
    chk_reg("t4_isooff0", 12'h00C, 32'h0000_0063);
    chk("t4_sin", 32'(sleep_in), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t4_iso_hold", 32'(iso), 32'd1);
      chk("t4_sin_hold", 32'(sleep_in), 32'd0);
    end
    step();
    chk_reg("t4_rstoff0", 12'h00C, 32'h0000_0073);
    chk("t4_iso_drop", 32'(iso), 32'd0);
    step(); step(); step(); step();
    chk_reg("t4_done", 12'h00C, 32'h0000_0004);
    lpmd_b = 2'b11;
    step();
    apb_write(12'h008, 32'h0000_0001);
    chk_reg("t4_idle", 12'h00C, 32'h0000_0000);

    // ---------------- T5 W1C vs. set race ----------------
    apb_write(12'h000, 32'h0000_0000);
    lpmd_b = 2'b10;
    step();
    wake_src = 4'b0100;
    step();
    wake_src = 4'b0000;
    chk_reg("t5_pend_pre", 12'h008, 32'h0000_0004);
    step();
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 12'h008; pwdata = 32'h0000_0004;
    step();
    penable = 1'b1;
    wake_src = 4'b0100;
    step();
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    wake_src = 4'b0000;
    chk_reg("t5_race", 12'h008, 32'h0000_0004);
    apb_write(12'h000, 32'h0000_0004);
    lpmd_b = 2'b11;
    step();
    chk_reg("t5_awake", 12'h00C, 32'h0000_0004);
    step();
    apb_write(12'h008, 32'h0000_0004);
    chk_reg("t5_pend_clr", 12'h008, 32'h0000_0000);

    // ---------------- T6 reset in OFF ----------------
    apb_write(12'h004, 32'h0000_0000);
    apb_write(12'h000, 32'h8000_0001);
    lpmd_b = 2'b00;
    step(); step(); step(); step();
    chk_reg("t6_offreq", 12'h00C, 32'h0000_0033);
    sleep_out = 1'b1;
    step();
    chk_reg("t6_off", 12'h00C, 32'h0000_0043);
    pad_cpu_rst_b = 1'b0;
    #1;
    chk("t6_iso", 32'(iso), 32'd0);
    chk("t6_sin", 32'(sleep_in), 32'd0);
    chk("t6_rb", 32'(pg_reset_b), 32'd0);
    chk("t6_ge0_rst", 32'(gate_en0), 32'd1);
    chk_reg("t6_stat", 12'h00C, 32'h0000_0000);
    chk_reg("t6_ctrl", 12'h000, 32'h0000_0000);
    sleep_out = 1'b0;
    lpmd_b = 2'b11;
    step();
    pad_cpu_rst_b = 1'b1;
    step();
    chk("t6_ge0", 32'(gate_en0), 32'd1);
    chk("t6_rb_rel", 32'(pg_reset_b), 32'd1);
    chk_reg("t6_stat_rel", 12'h00C, 32'h0000_0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
